// File: rtl/mcb_pkg.sv
// mcb_pkg: MCB instruction codes, pattern-mode encodings and write-generator state encoding
package mcb_pkg;
  localparam logic [2:0] MCB_WR = 3'b000;
  localparam logic [2:0] MCB_RD = 3'b001;
  typedef enum logic [1:0] {
    PAT_ALT  = 2'd0,
    PAT_INCR = 2'd1,
    PAT_PRBS = 2'd2,
    PAT_ALT2 = 2'd3
  } pat_mode_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CMD,
    S_NEXT,
    S_DONE
  } wr_state_e;
endpackage

// File: rtl/mcb_pattern_src.sv
// mcb_pattern_src: AA/55, incrementing and PRBS31 word source (clk, rst, load restarts, step advances, mode selects, data is current word)
module mcb_pattern_src
  import mcb_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [1:0]    mode,
  output logic [DW-1:0] data
);
  logic          alt;
  logic [31:0]   incr;
  logic [30:0]   lfsr;
  logic [DW-1:0] alt_w;
  assign alt_w = {(DW/8){alt ? 8'h55 : 8'hAA}};
  always_ff @(posedge clk or posedge rst)
    if (rst || load) begin
      alt  <= 1'b0;
      incr <= '0;
      lfsr <= 31'h1;
    end else if (step) begin
      alt  <= ~alt;
      incr <= incr + 32'd1;
      lfsr <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
    end
  always_comb begin
    data = '0;
    for (int i = 0; i < DW/32; i++)
      data[i*32 +: 32] = mode == PAT_INCR ? incr :
                         mode == PAT_PRBS ? {1'b0, lfsr} ^ 32'(i) : alt_w[i*32 +: 32];
  end
endmodule

// File: rtl/mcb_wr_pattern_gen.sv
// mcb_wr_pattern_gen: MCB write-traffic generator; start/stop/mode/burst_num control, wr_full/cmd_full backpressure, wr_* and cmd_* MCB strobes, busy/done/burst_cnt status
module mcb_wr_pattern_gen
  import mcb_pkg::*;
#(
  parameter int            DW        = 128,
  parameter int            AW        = 30,
  parameter int            BL        = 64,
  parameter logic [AW-1:0] ADDR_BASE = '0,
  parameter logic [AW-1:0] ADDR_END  = 30'h1000_0000,
  parameter int            ADDR_INC  = BL*DW/8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [15:0]     burst_num,
  input  logic            wr_full,
  input  logic            cmd_full,
  output logic            wr_en,
  output logic [DW-1:0]   wr_data,
  output logic [DW/8-1:0] wr_mask,
  output logic            cmd_en,
  output logic [2:0]      cmd_instr,
  output logic [5:0]      cmd_bl,
  output logic [AW-1:0]   cmd_byte_addr,
  output logic            busy,
  output logic            done,
  output logic [15:0]     burst_cnt
);
  wr_state_e   state, state_nx;
  logic [1:0]  mode_q;
  logic [15:0] bnum_q;
  logic [6:0]  wcnt;
  logic        stop_q;
  logic        launch;
  logic        last_word;
  logic        last_burst;
  logic [AW:0] addr_nx;
  assign launch     = state == S_IDLE && start;
  assign last_word  = wcnt == 7'(BL-1);
  assign last_burst = stop_q || (bnum_q != 16'd0 && burst_cnt + 16'd1 == bnum_q);
  assign addr_nx    = {1'b0, cmd_byte_addr} + (AW+1)'(ADDR_INC);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE ? (start ? S_FILL : S_IDLE) :
               state == S_FILL ? (wr_en && last_word ? S_CMD : S_FILL) :
               state == S_CMD  ? (cmd_en ? S_NEXT : S_CMD) :
               state == S_NEXT ? (last_burst ? S_DONE : S_FILL) : S_IDLE;
  end
  always_comb begin
    wr_en  = state == S_FILL && !wr_full;
    cmd_en = state == S_CMD && !cmd_full;
    busy   = state != S_IDLE;
    done   = state == S_DONE;
  end
  assign wr_mask   = '0;
  assign cmd_instr = MCB_WR;
  assign cmd_bl    = 6'(BL-1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q        <= '0;
      bnum_q        <= '0;
      burst_cnt     <= '0;
      cmd_byte_addr <= ADDR_BASE;
      wcnt          <= '0;
      stop_q        <= 1'b0;
    end else begin
      if (launch) begin
        mode_q        <= mode;
        bnum_q        <= burst_num;
        burst_cnt     <= '0;
        cmd_byte_addr <= ADDR_BASE;
        stop_q        <= 1'b0;
      end else if (busy && stop) stop_q <= 1'b1;
      if (wr_en) wcnt <= last_word ? '0 : wcnt + 7'd1;
      if (state == S_NEXT) begin
        burst_cnt     <= burst_cnt + 16'd1;
        cmd_byte_addr <= addr_nx >= {1'b0, ADDR_END} ? ADDR_BASE : addr_nx[AW-1:0];
      end
    end
  mcb_pattern_src #(.DW(DW)) u_src (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .step (wr_en),
    .mode (mode_q),
    .data (wr_data)
  );
endmodule

// File: tb/tb_mcb_wr_pattern_gen.sv
// tb_mcb_wr_pattern_gen: scoreboard bench for mcb_wr_pattern_gen with DW=128, BL=4 and a two-burst address window
module tb_mcb_wr_pattern_gen;
  localparam int DW = 128;
  localparam int AW = 30;
  localparam int BL = 4;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            wr_full = 1'b0;
  logic            cmd_full = 1'b0;
  logic [1:0]      mode = '0;
  logic [15:0]     burst_num = '0;
  logic            wr_en, cmd_en, busy, done;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_mask;
  logic [2:0]      cmd_instr;
  logic [5:0]      cmd_bl;
  logic [AW-1:0]   cmd_byte_addr;
  logic [15:0]     burst_cnt;
  int checks = 0;
  int errors = 0;
  int words_since = 0;
  int cmd_seen = 0;
  int c0 = 0;
  logic [DW-1:0] wq[$];
  logic [AW-1:0] aq[$];
  always #5 clk = ~clk;
  mcb_wr_pattern_gen #(
    .DW(DW), .AW(AW), .BL(BL), .ADDR_BASE(30'h0), .ADDR_END(30'h80)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .burst_num     (burst_num),
    .wr_full       (wr_full),
    .cmd_full      (cmd_full),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .cmd_en        (cmd_en),
    .cmd_instr     (cmd_instr),
    .cmd_bl        (cmd_bl),
    .cmd_byte_addr (cmd_byte_addr),
    .busy          (busy),
    .done          (done),
    .burst_cnt     (burst_cnt)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_run(input logic [1:0] m, input int nb);
    logic [30:0]   l = 31'h1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] w;
    for (int k = 0; k < nb*BL; k++) begin
      for (int i = 0; i < DW/32; i++)
        w[i*32 +: 32] = m == 2'd1 ? 32'(k) :
                        m == 2'd2 ? {1'b0, l} ^ 32'(i) :
                        (k % 2 == 1 ? 32'h5555_5555 : 32'hAAAA_AAAA);
      wq.push_back(w);
      l = {l[29:0], l[30] ^ l[27]};
    end
    for (int b = 0; b < nb; b++) begin
      aq.push_back(a);
      a = (a == 30'h0) ? 30'h40 : 30'h0;
    end
  endtask
  task automatic start_run(input logic [1:0] m, input logic [15:0] n);
    @(posedge clk); #1;
    mode = m;
    burst_num = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input logic [15:0] n);
    int t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 128'(done), 128'(1));
    chk("burst_cnt_at_done", 128'(burst_cnt), 128'(n));
    @(negedge clk);
    chk("done_single_cycle", 128'(done), 128'(0));
    chk("idle_after_done", 128'(busy), 128'(0));
    chk("words_drained", 128'(wq.size()), 128'(0));
    chk("cmds_drained", 128'(aq.size()), 128'(0));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 128'(wr_en), 128'(0));
    chk({tag, "_cmd_en"}, 128'(cmd_en), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_burst_cnt"}, 128'(burst_cnt), 128'(0));
    chk({tag, "_addr"}, 128'(cmd_byte_addr), 128'(0));
    chk({tag, "_wr_data"}, wr_data, {16{8'hAA}});
  endtask
  always @(negedge clk)
    if (rst) words_since = 0;
    else begin
      if (wr_full) chk("wr_en_while_full", 128'(wr_en), 128'(0));
      if (cmd_full) chk("cmd_en_while_full", 128'(cmd_en), 128'(0));
      if (wr_en) begin
        chk("wr_burst_overrun", 128'(words_since < BL), 128'(1));
        chk("wr_unexpected", 128'(wq.size() != 0), 128'(1));
        if (wq.size() != 0) chk("wr_data", wr_data, wq.pop_front());
        chk("wr_mask", 128'(wr_mask), 128'(0));
        words_since++;
      end
      if (cmd_en) begin
        chk("cmd_after_full_burst", 128'(words_since), 128'(BL));
        chk("cmd_unexpected", 128'(aq.size() != 0), 128'(1));
        if (aq.size() != 0) chk("cmd_addr", 128'(cmd_byte_addr), 128'(aq.pop_front()));
        chk("cmd_bl", 128'(cmd_bl), 128'(3));
        chk("cmd_instr", 128'(cmd_instr), 128'(0));
        words_since = 0;
        cmd_seen++;
      end
    end
  initial begin
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    push_run(2'd0, 2);
    start_run(2'd0, 16'd2);
    wait_done(16'd2);
    push_run(2'd1, 1);
    start_run(2'd1, 16'd1);
    @(posedge clk); #1;
    wr_full = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wr_full = 1'b0;
    wait_done(16'd1);
    push_run(2'd0, 3);
    start_run(2'd0, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    mode = 2'd1;
    burst_num = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(16'd3);
    push_run(2'd1, 1);
    cmd_full = 1'b1;
    c0 = cmd_seen;
    start_run(2'd1, 16'd1);
    repeat (14) @(posedge clk);
    #1;
    chk("cmd_held_off", 128'(cmd_seen), 128'(c0));
    cmd_full = 1'b0;
    wait_done(16'd1);
    push_run(2'd1, 5);
    c0 = cmd_seen;
    start_run(2'd1, 16'd0);
    for (int t = 0; t < 400 && cmd_seen < c0 + 4; t++) @(negedge clk);
    chk("fourth_cmd_reached", 128'(cmd_seen), 128'(c0 + 4));
    @(posedge clk);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(16'd5);
    push_run(2'd0, 1);
    start_run(2'd0, 16'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_fill_rst");
    wq.delete();
    aq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_run(2'd2, 1);
    start_run(2'd2, 16'd1);
    chk("prbs_first_word", wr_data, 128'h00000002_00000003_00000000_00000001);
    wait_done(16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
